// File: rtl/tick_timer_arb.sv
// -----------------------------------------------------------------------------
// tick_timer_arb
//
// Purpose:
//   One shared delay down-counter, time-multiplexed between NREQ requesters
//   by round-robin arbitration. A requester asks to wait dly ticks of either
//   the microsecond or the millisecond strobe. It holds req until it sees a
//   level done, then drops req to hand the timer back.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   CW    delay count width in ticks
//
// Ports:
//   clk_i      clock (the only clock)
//   rst_ni     asynchronous active-low reset
//   us_tck_i   1-cycle microsecond strobe, synchronous to clk_i
//   ms_tck_i   1-cycle millisecond strobe, synchronous to clk_i
//   req_i      per-requester request level
//   unit_i     per-requester tick select: 0 = us_tck_i, 1 = ms_tck_i
//   dly_i      per-requester delay; slice i = dly_i[i*CW +: CW]
//   gnt_o      one-hot grant, registered
//   done_o     one-hot completion level, registered
//   busy_o     timer owned (state is not IDLE)
//   remain_o   live count, 0 in IDLE          (TICK_TIMER_REMAIN_EN only)
//   owner_o    index of the granted requester (TICK_TIMER_REMAIN_EN only)
//
// Optional feature macro: TICK_TIMER_REMAIN_EN adds remain_o/owner_o for
// debug display. Core behaviour is the same with or without it.
// -----------------------------------------------------------------------------
module tick_timer_arb #(
    parameter int NREQ = 4,
    parameter int CW   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      us_tck_i,
    input  logic                      ms_tck_i,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0]           unit_i,
    input  logic [NREQ*CW-1:0]        dly_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [NREQ-1:0]           done_o,
    output logic                      busy_o
`ifdef TICK_TIMER_REMAIN_EN
    ,
    output logic [CW-1:0]             remain_o,
    output logic [$clog2(NREQ)-1:0]   owner_o
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             usel_q,   usel_d;
    logic [NREQ-1:0]  gnt_q,    gnt_d;
    logic [NREQ-1:0]  done_q,   done_d;
    logic [IDX_W-1:0] owner_q,  owner_d;
    logic [IDX_W-1:0] rrPtr_q,  rrPtr_d;

    logic             winFound;
    logic [IDX_W-1:0] winIdx;
    logic [IDX_W-1:0] candIdx;
    logic [CW-1:0]    winDly;
    logic             tickSel;
    logic             ownerReq;

    // Round-robin pick: scan offsets from the highest down so that the
    // request closest at-or-after rrPtr_q is the last one written and wins.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            candIdx = IDX_W'((int'(rrPtr_q) + k) % NREQ);
            if (req_i[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    assign winDly   = dly_i[winIdx*CW +: CW];
    // Only the tick matching the owner's unit counts, even if both strobe together.
    assign tickSel  = usel_q ? ms_tck_i : us_tck_i;
    assign ownerReq = req_i[owner_q];

    // Next-state logic for the IDLE -> COUNT -> DONE -> IDLE handshake.
    // unit/dly are looked at only on the grant edge; afterwards the owner's
    // req level alone decides whether the transaction continues.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        usel_d  = usel_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (winFound) begin
                    gnt_d         = '0;
                    gnt_d[winIdx] = 1'b1;
                    owner_d       = winIdx;
                    cnt_d         = winDly;
                    usel_d        = unit_i[winIdx];
                    rrPtr_d       = IDX_W'((int'(winIdx) + 1) % NREQ);
                    if (winDly == '0) begin
                        done_d         = '0;
                        done_d[winIdx] = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                // An abort takes priority over a tick arriving in the same cycle.
                if (!ownerReq) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (tickSel) begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_d           = '0;
                        done_d          = '0;
                        done_d[owner_q] = 1'b1;
                        state_d         = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!ownerReq) begin
                    gnt_d   = '0;
                    done_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                done_d  = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset restarts arbitration from requester 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            usel_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            owner_q <= '0;
            rrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            usel_q  <= usel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign busy_o = (state_q != ST_IDLE);

`ifdef TICK_TIMER_REMAIN_EN
    assign remain_o = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign owner_o  = owner_q;
`endif

endmodule

// File: tb/tb_tick_timer_arb.sv
// -----------------------------------------------------------------------------
// tb_tick_timer_arb
//
// Directed bench for tick_timer_arb (NREQ=4, CW=16). Inputs are driven 1 time
// unit after each rising edge and outputs are checked at the same point, so
// every check sees the registers settled after the preceding edge.
// -----------------------------------------------------------------------------
module tb_tick_timer_arb;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic              clk;
    logic              rstN;
    logic              usTck;
    logic              msTck;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   unitSel;
    logic [NREQ*CW-1:0] dlyIn;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
`ifdef TICK_TIMER_REMAIN_EN
    logic [CW-1:0]     remain;
    logic [1:0]        owner;
`endif

    int assertCount = 0;
    int failCount   = 0;

    tick_timer_arb #(
        .NREQ(NREQ),
        .CW  (CW)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rstN),
        .us_tck_i(usTck),
        .ms_tck_i(msTck),
        .req_i   (req),
        .unit_i  (unitSel),
        .dly_i   (dlyIn),
        .gnt_o   (gnt),
        .done_o  (done),
        .busy_o  (busy)
`ifdef TICK_TIMER_REMAIN_EN
        ,
        .remain_o(remain),
        .owner_o (owner)
`endif
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive request and unit levels together.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] u);
        req     = r;
        unitSel = u;
    endtask

    task automatic setDly(input int idx, input logic [CW-1:0] v);
        dlyIn[idx*CW +: CW] = v;
    endtask

    // One selected-tick pulse lasting exactly one edge.
    task automatic pulseTick(input logic us, input logic ms);
        usTck = us;
        msTck = ms;
        stepCycles(1);
        usTck = 1'b0;
        msTck = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [NREQ-1:0] expGnt,
                               input logic [NREQ-1:0] expDone, input logic expBusy);
        assertCount++;
        assert (gnt === expGnt) else begin
            failCount++;
            $error("[TB] FAIL %s gnt: observed=%b expected=%b", tag, gnt, expGnt);
        end
        assertCount++;
        assert (done === expDone) else begin
            failCount++;
            $error("[TB] FAIL %s done: observed=%b expected=%b", tag, done, expDone);
        end
        assertCount++;
        assert (busy === expBusy) else begin
            failCount++;
            $error("[TB] FAIL %s busy: observed=%b expected=%b", tag, busy, expBusy);
        end
    endtask

    initial begin
        int order [4];

        rstN    = 1'b0;
        usTck   = 1'b0;
        msTck   = 1'b0;
        req     = '0;
        unitSel = '0;
        dlyIn   = '0;

        // Reset state
        #12;
        checkOutput("reset", 4'b0000, 4'b0000, 1'b0);
        rstN = 1'b1;
        stepCycles(1);
        checkOutput("post_reset_idle", 4'b0000, 4'b0000, 1'b0);

        // Single req0, us unit, dly=3; a tick in the grant cycle is ignored
        $display("[TB] single request, dly=3 us");
        setDly(0, 16'd3);
        applyStimulus(4'b0001, 4'b0000);
        usTck = 1'b1;
        stepCycles(1);
        usTck = 1'b0;
        checkOutput("t2_grant", 4'b0001, 4'b0000, 1'b1);
`ifdef TICK_TIMER_REMAIN_EN
        assertCount++;
        assert (remain === 16'd3) else begin
            failCount++;
            $error("[TB] FAIL t2_remain: observed=%0d expected=3", remain);
        end
        assertCount++;
        assert (owner === 2'd0) else begin
            failCount++;
            $error("[TB] FAIL t2_owner: observed=%0d expected=0", owner);
        end
`endif
        for (int t = 1; t <= 3; t++) begin
            stepCycles(26);
            pulseTick(1'b1, 1'b0);
            if (t == 2) checkOutput("t2_after_tick2", 4'b0001, 4'b0000, 1'b1);
        end
        checkOutput("t2_done", 4'b0001, 4'b0001, 1'b1);
        stepCycles(5);
        checkOutput("t2_done_held", 4'b0001, 4'b0001, 1'b1);
        applyStimulus(4'b0000, 4'b0000);
        stepCycles(1);
        checkOutput("t2_idle", 4'b0000, 4'b0000, 1'b0);

        // req1 with dly=0 goes straight to DONE
        $display("[TB] zero delay request");
        setDly(1, 16'd0);
        applyStimulus(4'b0010, 4'b0000);
        stepCycles(1);
        checkOutput("t3_grant_done", 4'b0010, 4'b0010, 1'b1);
        stepCycles(3);
        checkOutput("t3_held", 4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0000, 4'b0000);
        stepCycles(1);
        checkOutput("t3_idle", 4'b0000, 4'b0000, 1'b0);

        // Reset mid-COUNT (rr pointer is 2 here, so req2 is granted)
        $display("[TB] reset during count");
        setDly(2, 16'd5);
        applyStimulus(4'b0100, 4'b0000);
        stepCycles(1);
        checkOutput("t1_grant", 4'b0100, 4'b0000, 1'b1);
        pulseTick(1'b1, 1'b0);
        checkOutput("t1_counting", 4'b0100, 4'b0000, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("t1_async_reset", 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        #2;
        rstN = 1'b1;
        stepCycles(1);
        checkOutput("t1_idle_after_reset", 4'b0000, 4'b0000, 1'b0);

        // All four together, dly=1; req0 re-raised at once must wait for 1,2,3
        $display("[TB] round-robin with all requesters");
        for (int i = 0; i < NREQ; i++) setDly(i, 16'd1);
        applyStimulus(4'b1111, 4'b0000);
        stepCycles(1);
        checkOutput("t4_grant0", 4'b0001, 4'b0000, 1'b1);
        pulseTick(1'b1, 1'b0);
        checkOutput("t4_done0", 4'b0001, 4'b0001, 1'b1);
        applyStimulus(4'b1110, 4'b0000);
        stepCycles(1);
        checkOutput("t4_idle0", 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 4'b0000);
        order = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            logic [NREQ-1:0] mask;
            mask = NREQ'(1) << order[i];
            stepCycles(1);
            checkOutput($sformatf("t4_grant_%0d", i), mask, 4'b0000, 1'b1);
            pulseTick(1'b1, 1'b0);
            checkOutput($sformatf("t4_done_%0d", i), mask, mask, 1'b1);
            applyStimulus(req & ~mask, 4'b0000);
            stepCycles(1);
            checkOutput($sformatf("t4_idle_%0d", i), 4'b0000, 4'b0000, 1'b0);
        end

        // Abort: req2 (ms, dly=5) dropped after one tick; pending req3 follows
        $display("[TB] abort during count");
        setDly(2, 16'd5);
        setDly(3, 16'd0);
        applyStimulus(4'b1100, 4'b0100);
        stepCycles(1);
        checkOutput("t5_grant2", 4'b0100, 4'b0000, 1'b1);
        pulseTick(1'b0, 1'b1);
        checkOutput("t5_one_tick", 4'b0100, 4'b0000, 1'b1);
        applyStimulus(4'b1000, 4'b0000);
        stepCycles(1);
        checkOutput("t5_aborted", 4'b0000, 4'b0000, 1'b0);
        stepCycles(1);
        checkOutput("t5_grant3", 4'b1000, 4'b1000, 1'b1);
        applyStimulus(4'b0000, 4'b0000);
        stepCycles(1);
        checkOutput("t5_idle", 4'b0000, 4'b0000, 1'b0);

        // ms unit with coincident ticks; lone us ticks must not count
        $display("[TB] coincident ticks, ms unit");
        setDly(1, 16'd2);
        applyStimulus(4'b0010, 4'b0010);
        stepCycles(1);
        checkOutput("t6_grant1", 4'b0010, 4'b0000, 1'b1);
        pulseTick(1'b1, 1'b1);
        checkOutput("t6_after_ms1", 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycles(2);
            pulseTick(1'b1, 1'b0);
        end
        checkOutput("t6_us_ignored", 4'b0010, 4'b0000, 1'b1);
        pulseTick(1'b1, 1'b1);
        checkOutput("t6_done", 4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0000, 4'b0000);
        stepCycles(1);
        checkOutput("t6_idle", 4'b0000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
